// File: rtl/usb_rx_buffer_pkg.sv
// usb_rx_buffer_pkg: shared fetch-FSM state encodings and ASCII codes used
// by the USB receive buffer.
package usb_rx_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STROBE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_GAP     = 2'd3
   } rx_state_t;

   localparam logic [6:0] ASCII_LF   = 7'h0A;
   localparam logic [6:0] ASCII_LC_A = 7'h61;
   localparam logic [6:0] ASCII_LC_Z = 7'h7A;

endpackage

// File: rtl/usb_rx_buffer_sync_fifo.sv
// usb_rx_buffer_sync_fifo: DEPTH x W circular buffer with a registered head
// output. A push is accepted at full only when a pop frees a slot in the same
// cycle; a pop is ignored when empty.
module usb_rx_buffer_sync_fifo
   import usb_rx_buffer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int W     = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  data,
   output logic [AW:0]   level,
   output logic          empty,
   output logic          full
);

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_FULL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // storage write; contents need no reset since level gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // pointers and occupancy; pointers wrap naturally mod DEPTH
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // registered head; holds its last value while empty
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      data <= '0;
      else if (!empty) data <= mem[rd_ptr];
   end

endmodule

// File: rtl/usb_rx_buffer.sv
// usb_rx_buffer: fetches bytes from an FT245 FIFO, drops LF, buffers them and
// presents an FT245-like read port (rxf/rd/data) to the multiplexer.
// Build option RX_UPCASE_EN: lower-case letters 'a'..'z' are folded to upper
// case before they enter the buffer.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | usb_rd high; wait for byte available, room, bus free
//   STROBE  | usb_rd low; counting down the FT245 access time
//   CAPTURE | sample usb_data, raise usb_rd, push unless filtered
//   GAP     | usb_rd high; counting down recovery before next read
module usb_rx_buffer
   import usb_rx_buffer_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int RD_WAIT = 4,
   parameter int RD_GAP  = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          usb_rxf,
   output logic          usb_rd,
   input  logic [7:0]    usb_data,
   input  logic          tx_busy,
   output logic          rxf,
   input  logic          rd,
   output logic [6:0]    data,
   output logic [AW:0]   level
);

   // usb_rd is low for RD_WAIT cycles total: STROBE cycles plus CAPTURE
   localparam int        WAIT_LOAD_I = (RD_WAIT >= 2) ? RD_WAIT - 2 : 0;
   localparam logic [7:0] WAIT_LOAD  = 8'(WAIT_LOAD_I);
   localparam logic [7:0] GAP_LOAD   = 8'(RD_GAP - 1);

   rx_state_t  state;
   logic [7:0] cnt;
   logic       rxf_meta;
   logic       rxf_s;
   logic       rd_q;
   logic       pop;
   logic       push;
   logic [6:0] rx_code;
   logic       fifo_empty;
   logic       fifo_full;
   logic       usb_data_unused;

   assign usb_data_unused = usb_data[7];

   // two-flop synchroniser for the asynchronous RXF# input
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxf_meta <= 1'b1;
         rxf_s    <= 1'b1;
      end else begin
         rxf_meta <= usb_rxf;
         rxf_s    <= rxf_meta;
      end
   end

   // previous rd level for 0->1 pop detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_q <= 1'b1;
      else        rd_q <= rd;
   end

   assign pop = !rd_q && rd;

   // byte filter: bit 7 dropped, optional upper-case folding
   always_comb begin
      rx_code = usb_data[6:0];
`ifdef RX_UPCASE_EN
      if (rx_code >= ASCII_LC_A && rx_code <= ASCII_LC_Z)
         rx_code = rx_code & 7'h5F;
`endif
   end

   assign push = (state == ST_CAPTURE) && (usb_data[6:0] != ASCII_LF);

   // fetch sequencer driving the FT245 read strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         usb_rd <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!rxf_s && !fifo_full && !tx_busy) begin
                  usb_rd <= 1'b0;
                  cnt    <= WAIT_LOAD;
                  state  <= (RD_WAIT == 1) ? ST_CAPTURE : ST_STROBE;
               end
            end
            ST_STROBE: begin
               if (cnt == '0) state <= ST_CAPTURE;
               else           cnt   <= cnt - 1'b1;
            end
            ST_CAPTURE: begin
               usb_rd <= 1'b1;
               cnt    <= GAP_LOAD;
               state  <= ST_GAP;
            end
            ST_GAP: begin
               if (cnt == '0) state <= ST_IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // registered empty flag towards the multiplexer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rxf <= 1'b1;
      else        rxf <= fifo_empty;
   end

   usb_rx_buffer_sync_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (7)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (rx_code),
      .pop       (pop),
      .data      (data),
      .level     (level),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule

// File: tb/tb_usb_rx_buffer.sv
// tb_usb_rx_buffer: directed bench for usb_rx_buffer with a small FT245
// model (byte queue, data driven one cycle after RD# falls).
module tb_usb_rx_buffer;

   localparam int DEPTH   = 8;
   localparam int AW      = 3;
   localparam int RD_WAIT = 4;
   localparam int RD_GAP  = 2;

`ifdef RX_UPCASE_EN
   localparam logic [6:0] EXP_LC_A = 7'h41;
`else
   localparam logic [6:0] EXP_LC_A = 7'h61;
`endif

   logic          clk;
   logic          reset;
   logic          usb_rxf;
   logic          usb_rd;
   logic [7:0]    usb_data;
   logic          tx_busy;
   logic          rxf;
   logic          rd;
   logic [6:0]    data;
   logic [AW:0]   level;

   int tests;
   int failed;
   int cyc;
   int rise_cyc;
   int strobe_cnt;
   int last_width;
   int width_bad;
   int min_gap;
   int mdl_n;
   int mdl_gap;
   logic [7:0] q[$];

   usb_rx_buffer #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .RD_WAIT (RD_WAIT),
      .RD_GAP  (RD_GAP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .usb_rxf  (usb_rxf),
      .usb_rd   (usb_rd),
      .usb_data (usb_data),
      .tx_busy  (tx_busy),
      .rxf      (rxf),
      .rd       (rd),
      .data     (data),
      .level    (level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // FT245 model: strobe width and gap measurement, data after one cycle
   always @(negedge usb_rd) begin
      strobe_cnt++;
      mdl_gap = cyc - rise_cyc;
      if (mdl_gap < min_gap) min_gap = mdl_gap;
      @(posedge clk);
      #1;
      usb_data = (q.size() > 0) ? q[0] : 8'hFF;
      mdl_n = 1;
      while (usb_rd === 1'b0 && mdl_n < 64) begin
         @(posedge clk);
         #1;
         mdl_n++;
      end
      last_width = mdl_n;
      if (mdl_n != RD_WAIT) width_bad++;
   end

   always @(posedge usb_rd) begin
      rise_cyc = cyc;
      if (q.size() > 0) void'(q.pop_front());
      usb_rxf = (q.size() == 0);
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      q.push_back(b);
      usb_rxf = 1'b0;
   endtask

   task automatic pop_byte(output logic [6:0] b);
      b  = data;
      rd = 1'b0;
      @(posedge clk); #1;
      rd = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic wait_rxf_low(input string tag, input int max, output int n);
      n = 0;
      while (rxf !== 1'b0 && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq({tag, " rxf low"}, rxf, 0);
   endtask

   task automatic wait_usb_rd_low(input string tag, input int max);
      int n;
      n = 0;
      while (usb_rd !== 1'b0 && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq({tag, " usb_rd low"}, usb_rd, 0);
   endtask

   task automatic wait_strobes(input int target, input int max);
      int n;
      n = 0;
      while (strobe_cnt < target && n < max) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   initial begin
      logic [6:0] b;
      int n;
      int base;

      tests = 0; failed = 0; cyc = 0; rise_cyc = 0; strobe_cnt = 0;
      last_width = 0; width_bad = 0; min_gap = 99;
      usb_rxf = 1'b1; usb_data = 8'h00; tx_busy = 1'b0; rd = 1'b1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset usb_rd", usb_rd, 1);
      check_eq("reset rxf", rxf, 1);
      check_eq("reset data", data, 0);
      check_eq("reset level", level, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: single byte, latency, width, pop, pop-when-empty
      send(8'h41);
      wait_rxf_low("t1", 40, n);
      check_eq("t1 latency", n, 2 + 1 + RD_WAIT + 1);
      check_eq("t1 strobe width", last_width, RD_WAIT);
      check_eq("t1 data", data, 7'h41);
      check_eq("t1 level", level, 1);
      pop_byte(b);
      check_eq("t1 rxf after pop", rxf, 1);
      check_eq("t1 level after pop", level, 0);
      pop_byte(b);
      check_eq("t1 pop empty level", level, 0);
      check_eq("t1 pop empty rxf", rxf, 1);

      // 2: LF is read from the FT245 but not stored
      base = strobe_cnt;
      send(8'h41); send(8'h0A); send(8'h42);
      wait_strobes(base + 3, 200);
      repeat (12) @(posedge clk);
      #1;
      check_eq("t2 strobes", strobe_cnt - base, 3);
      check_eq("t2 level", level, 2);
      pop_byte(b);
      check_eq("t2 first", b, 7'h41);
      check_eq("t2 second", data, 7'h42);
      pop_byte(b);
      check_eq("t2 drained", level, 0);

      // 3: ten bytes, no pops: stops at full
      base = strobe_cnt; min_gap = 99; width_bad = 0;
      for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
      wait_strobes(base + 8, 400);
      repeat (30) @(posedge clk);
      #1;
      check_eq("t3 strobes at full", strobe_cnt - base, 8);
      check_eq("t3 level full", level, DEPTH);
      check_eq("t3 usb_rd idle", usb_rd, 1);
      check_eq("t3 min gap", min_gap, RD_GAP + 1);
      check_eq("t3 widths", width_bad, 0);
      pop_byte(b);
      check_eq("t3 pop value", b, 7'h30);
      wait_strobes(base + 9, 50);
      repeat (10) @(posedge clk);
      #1;
      check_eq("t3 ninth strobe", strobe_cnt - base, 9);
      check_eq("t3 level refill", level, DEPTH);

      // 4a: pop aligned with capture edge keeps level unchanged
      pop_byte(b);
      check_eq("t4 pop value", b, 7'h31);
      wait_usb_rd_low("t4 tenth", 10);
      @(posedge clk);
      @(posedge clk); #1;
      rd = 1'b0;
      @(posedge clk); #1;
      check_eq("t4 level before capture", level, DEPTH - 1);
      rd = 1'b1;
      @(posedge clk); #1;
      check_eq("t4 level push+pop", level, DEPTH - 1);
      @(posedge clk); #1;
      for (int i = 0; i < 7; i++) begin
         pop_byte(b);
         check_eq("t4 drain order", b, 7'h33 + 7'(i));
      end
      check_eq("t4 drained", level, 0);

      // 4b: tx_busy blocks a new read but not one already started
      tx_busy = 1'b1;
      base = strobe_cnt;
      send(8'h55);
      repeat (20) @(posedge clk);
      #1;
      check_eq("t4 busy no strobe", strobe_cnt - base, 0);
      check_eq("t4 busy usb_rd", usb_rd, 1);
      tx_busy = 1'b0;
      @(posedge clk); #1;
      check_eq("t4 release start", usb_rd, 0);
      tx_busy = 1'b1;
      wait_rxf_low("t4 busy", 20, n);
      check_eq("t4 busy width", last_width, RD_WAIT);
      check_eq("t4 busy data", data, 7'h55);
      tx_busy = 1'b0;
      pop_byte(b);

      // 5: reset in the middle of a strobe
      send(8'h65);
      wait_rxf_low("t5 pre", 40, n);
      check_eq("t5 pre level", level, 1);
      send(8'h66);
      wait_usb_rd_low("t5 strobe", 30);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_eq("t5 async usb_rd", usb_rd, 1);
      check_eq("t5 reset level", level, 0);
      check_eq("t5 reset rxf", rxf, 1);
      check_eq("t5 reset data", data, 0);
      #4;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      send(8'h67);
      wait_rxf_low("t5 post", 40, n);
      check_eq("t5 post width", last_width, RD_WAIT);
      check_eq("t5 post data", data, 7'h67);
      check_eq("t5 post level", level, 1);
      pop_byte(b);

      // 6: case folding and bit 7 stripping
      width_bad = 0;
      send(8'h61); send(8'hFB); send(8'h60);
      base = strobe_cnt;
      wait_strobes(base + 3, 200);
      repeat (12) @(posedge clk);
      #1;
      check_eq("t6 level", level, 3);
      pop_byte(b);
      check_eq("t6 lc a", b, EXP_LC_A);
      pop_byte(b);
      check_eq("t6 7B", b, 7'h7B);
      pop_byte(b);
      check_eq("t6 60", b, 7'h60);
      check_eq("t6 widths", width_bad, 0);
      check_eq("t6 drained rxf", rxf, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
